// File: rtl/mul_unit_ctrl_pkg.sv
// Shared definitions for the RV32M multiply unit sequencer.
// Opcode encodings, FSM state type and the signedness correction helper.
package mul_unit_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Turn the signed 64-bit product into the RV32M result for op.
    // The high-word fixups add back the operand weight lost when a
    // set sign bit was treated as negative; carries out are dropped.
    function automatic logic [XLEN-1:0] mul_result(
        input logic [1:0]        op,
        input logic [XLEN-1:0]   a,
        input logic [XLEN-1:0]   b,
        input logic [2*XLEN-1:0] p
    );
        logic [XLEN-1:0] ph;
        logic [XLEN-1:0] fix_a;
        logic [XLEN-1:0] fix_b;
        ph    = p[2*XLEN-1:XLEN];
        fix_a = b[XLEN-1] ? a : '0;
        fix_b = a[XLEN-1] ? b : '0;
        case (op)
            MUL_OP_MUL:    mul_result = p[XLEN-1:0];
            MUL_OP_MULH:   mul_result = ph;
            MUL_OP_MULHSU: mul_result = ph + fix_a;
            default:       mul_result = ph + fix_b + fix_a;
        endcase
    endfunction

endpackage

// File: rtl/mul_unit_ctrl_mult.sv
// Combinational 32x32 signed multiplier: radix-4 Booth partial
// products summed into a 64-bit product (tree left to synthesis).
module booth_wallace_multiplier
    import mul_unit_ctrl_pkg::*;
(
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] p
);

    logic [2*XLEN-1:0] a_ext;
    logic [XLEN:0]     b_ext;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] pp;
    logic [2:0]        grp;

    assign a_ext = {{XLEN{a[XLEN-1]}}, a};
    assign b_ext = {b, 1'b0};

    // Sum one Booth digit times a per 2-bit group of b.
    always_comb begin
        acc = '0;
        pp  = '0;
        grp = '0;
        for (int i = 0; i < XLEN / 2; i++) begin
            grp = b_ext[2*i +: 3];
            case (grp)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
        p = acc;
    end

endmodule

// File: rtl/mul_unit_ctrl.sv
// RV32M multiply unit sequencer around one booth_wallace_multiplier.
// Optional MUL_UNIT_FUSE_EN adds a one-entry product cache.
module mul_unit_ctrl
    import mul_unit_ctrl_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int CNT_W = $clog2(STAGES + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [TAG_W-1:0]  tag_q;
    logic [2*XLEN-1:0] prod_q;
    logic              raw_q;
    logic [2*XLEN-1:0] mul_p;
    logic [2*XLEN-1:0] p_src;
    logic              hit;

`ifdef MUL_UNIT_FUSE_EN
    logic [XLEN-1:0]   cache_a;
    logic [XLEN-1:0]   cache_b;
    logic [2*XLEN-1:0] cache_p;
    logic              cache_v;

    assign hit = cache_v
              && (req_rs1 == cache_a)
              && (req_rs2 == cache_b);
`else
    assign hit = 1'b0;
`endif

    // raw_q: product not yet captured, take it straight from the tree
    assign p_src = raw_q ? mul_p : prod_q;

    booth_wallace_multiplier u_mul (
        .a (a_q),
        .b (b_q),
        .p (mul_p)
    );

    // Sequencer FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            prod_q    <= '0;
            raw_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
`ifdef MUL_UNIT_FUSE_EN
            cache_a   <= '0;
            cache_b   <= '0;
            cache_p   <= '0;
            cache_v   <= 1'b0;
`endif
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            raw_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
`ifdef MUL_UNIT_FUSE_EN
            cache_v   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        a_q       <= req_rs1;
                        b_q       <= req_rs2;
                        tag_q     <= req_tag;
                        req_ready <= 1'b0;
                        if (hit) begin
`ifdef MUL_UNIT_FUSE_EN
                            prod_q <= cache_p;
`endif
                            raw_q  <= 1'b0;
                            state  <= DONE;
                        end else if (STAGES == 1) begin
                            raw_q  <= 1'b1;
                            state  <= DONE;
                        end else begin
                            raw_q  <= 1'b0;
                            cnt    <= CNT_W'(STAGES - 1);
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        prod_q  <= mul_p;
                        cnt     <= '0;
                        state   <= DONE;
`ifdef MUL_UNIT_FUSE_EN
                        cache_a <= a_q;
                        cache_b <= b_q;
                        cache_p <= mul_p;
                        cache_v <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= mul_result(op_q, a_q, b_q, p_src);
                        rsp_tag   <= tag_q;
                        if (raw_q) begin
                            prod_q  <= mul_p;
                            raw_q   <= 1'b0;
`ifdef MUL_UNIT_FUSE_EN
                            cache_a <= a_q;
                            cache_b <= b_q;
                            cache_p <= mul_p;
                            cache_v <= 1'b1;
`endif
                        end
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit_ctrl.sv
// Scoreboard bench for mul_unit_ctrl: randomized RV32M multiplies
// checked against an arithmetic reference model.
module tb_mul_unit_ctrl;

    localparam int STAGES = 2;
    localparam int TAG_W  = 5;
`ifdef MUL_UNIT_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hold = 0;
    bit          cv = 1'b0;
    logic [31:0] ca = '0;
    logic [31:0] cb = '0;

    mul_unit_ctrl #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_tag   (req_tag),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Extend each operand by its RV32M signedness and take the wanted half.
    function automatic logic [31:0] ref_mul(
        input logic [1:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic signed [65:0] x;
        logic signed [65:0] y;
        logic signed [65:0] p;
        x = (op == 2'b11) ? {34'b0, a} : {{34{a[31]}}, a};
        y = (op[1])       ? {34'b0, b} : {{34{b[31]}}, b};
        p = x * y;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!req_ready && w <= 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req_ready stuck at 0 for %0d cycles", w);
        end
    endtask

    task automatic issue(
        input logic [1:0]       op,
        input logic [31:0]      a,
        input logic [31:0]      b,
        input logic [TAG_W-1:0] tag,
        input bit               kill
    );
        exp_t e;
        bit   hit;
        wait_ready();
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_rs1   = $urandom;
        req_rs2   = $urandom;
        e.data = ref_mul(op, a, b);
        e.tag  = tag;
        e.acc  = cyc;
        hit    = FUSE && cv && (a == ca) && (b == cb);
        e.lat  = hit ? 1 : STAGES;
        if (!hit) begin
            ca = a;
            cb = b;
            cv = 1'b1;
        end
        q.push_back(e);
        if (kill) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            void'(q.pop_back());
            cv = 1'b0;
            chk("kill_req_ready", 64'(req_ready), 64'd1);
            chk("kill_rsp_valid", 64'(rsp_valid), 64'd0);
        end
    endtask

    task automatic flush_idle();
        wait_ready();
        req_valid = 1'b1;
        flush     = 1'b1;
        req_op    = 2'($urandom);
        req_rs1   = $urandom;
        req_rs2   = $urandom;
        req_tag   = TAG_W'($urandom);
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        cv        = 1'b0;
        chk("flush_req_ready", 64'(req_ready), 64'd1);
        chk("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] s[6];
        s = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
              32'h7FFF_FFFF, 32'h0000_FFFF};
        if ($urandom_range(0, 2) == 0) return s[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    // Monitor: pops the scoreboard at each new response and re-checks it
    // every cycle it is held; also drives rsp_ready.
    initial begin : mon
        exp_t e;
        bit   act;
        act = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                act = 1'b0;
            end else if (rsp_valid) begin
                chk("busy_req_ready", 64'(req_ready), 64'd0);
                if (!act) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got data %0h tag %0h, required no response",
                                 rsp_data, rsp_tag);
                        e.data = rsp_data;
                        e.tag  = rsp_tag;
                    end else begin
                        e = q.pop_front();
                        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                    act = 1'b1;
                end
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                if (hold > 0) begin
                    hold--;
                    rsp_ready = 1'b0;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                if (rsp_ready) act = 1'b0;
            end else begin
                act = 1'b0;
                rsp_ready = 1'($urandom);
            end
        end
    end

    initial begin : drv
        logic [31:0] a;
        logic [31:0] b;
        int          w;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_tag   = '0;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(2'b00, 32'd7, 32'd9, 5'd21, 1'b0);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
        issue(2'b01, -32'sd25, -32'sd13, 5'd2, 1'b0);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
        wait_ready();
        hold = 5;
        issue(2'b00, 32'h0001_2345, 32'h0000_6789, 5'd17, 1'b0);
        issue(2'b00, 32'd11, 32'd13, 5'd9, 1'b1);
        issue(2'b00, 32'd3, 32'd5, 5'd10, 1'b0);
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 1'b0);
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 1'b0);
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 1'b0);
        flush_idle();
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 1'b0);

        a = 32'd0;
        b = 32'd0;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                a = pick();
                b = pick();
            end
            if ($urandom_range(0, 14) == 0) flush_idle();
            if ($urandom_range(0, 19) == 0) begin
                wait_ready();
                hold = $urandom_range(1, 6);
            end
            issue(2'($urandom), a, b, TAG_W'($urandom),
                  $urandom_range(0, 9) == 0);
        end

        w = 0;
        while ((q.size() != 0 || rsp_valid || !req_ready) && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (q.size() != 0 || rsp_valid || !req_ready) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses still pending, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
